// File: rtl/mantissa_pp_accumulator_pkg.sv
// fmau_mul_pkg: shared constants, op encodings, FSM states and term mask
package fmau_mul_pkg;
   localparam int PP_W  = 14;
   localparam int NBLK  = 4;
   localparam int OUT_W = NBLK * PP_W;
   localparam int BLK_W = PP_W / 2;
   localparam logic [1:0] MUL_OP_FULL = 2'b00;
   localparam logic [1:0] MUL_OP_DUAL = 2'b01;
   localparam logic [1:0] MUL_OP_QUAD = 2'b10;
   typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
   // op 11 is reserved and behaves like a full 28x28 multiply
   function automatic logic keep(input logic [1:0] op, input logic [1:0] i, input logic [1:0] j);
      return op == MUL_OP_DUAL ? i[1] == j[1] : op == MUL_OP_QUAD ? i == j : 1'b1;
   endfunction
endpackage

// File: rtl/mantissa_pp_accumulator_if.sv
// mantissa_pp_accumulator_if: pp-set input handshake (in_valid/in_ready/op/pp_flat) and product output handshake (out_valid/out_ready/out/op_out)
interface mantissa_pp_accumulator_if;
   import fmau_mul_pkg::*;
   logic                       in_valid;
   logic                       in_ready;
   logic [1:0]                 op;
   logic [NBLK*NBLK*PP_W-1:0]  pp_flat;
   logic                       out_valid;
   logic                       out_ready;
   logic [OUT_W-1:0]           out;
   logic [1:0]                 op_out;
   modport master (output in_valid, op, pp_flat, out_ready, input in_ready, out_valid, out, op_out);
   modport slave  (input in_valid, op, pp_flat, out_ready, output in_ready, out_valid, out, op_out);
endinterface

// File: rtl/mantissa_pp_accumulator_pp_row_shifter.sv
// pp_row_shifter: masked, shifted sum of one partial-product row (i_row, i_pp_row, i_op -> o_sum)
module pp_row_shifter
   import fmau_mul_pkg::*;
(
   input  logic [1:0]           i_row,
   input  logic [NBLK*PP_W-1:0] i_pp_row,
   input  logic [1:0]           i_op,
   output logic [OUT_W-1:0]     o_sum
);
   always_comb begin
      o_sum = '0;
      for (int j = 0; j < NBLK; j++)
         if (keep(i_op, i_row, 2'(j)))
            o_sum = o_sum + (OUT_W'(i_pp_row[j*PP_W +: PP_W]) << (BLK_W * (int'(i_row) + j)));
   end
endmodule

// File: rtl/mantissa_pp_accumulator.sv
// mantissa_pp_accumulator: sums a 4x4 partial-product set one row per cycle into a 56-bit product (clk, rst_n, bus slave)
module mantissa_pp_accumulator
   import fmau_mul_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   mantissa_pp_accumulator_if.slave bus
);
   state_t                    r_state;
   state_t                    w_next;
   logic [1:0]                r_row;
   logic [OUT_W-1:0]          r_acc;
   logic [NBLK*NBLK*PP_W-1:0] r_pp;
   logic [1:0]                r_op;
   logic [OUT_W-1:0]          w_row_sum;
   pp_row_shifter u_shift (
      .i_row    (r_row),
      .i_pp_row (r_pp[int'(r_row)*NBLK*PP_W +: NBLK*PP_W]),
      .i_op     (r_op),
      .o_sum    (w_row_sum)
   );
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = bus.in_valid ? ACC : IDLE;
         ACC:     w_next = r_row == 2'd3 ? DONE : ACC;
         default: w_next = bus.out_ready ? IDLE : DONE;
      endcase
      bus.in_ready  = r_state == IDLE;
      bus.out_valid = r_state == DONE;
      bus.out       = r_state == DONE ? r_acc : '0;
      bus.op_out    = r_state == DONE ? r_op : 2'b00;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_row   <= '0;
         r_acc   <= '0;
         r_pp    <= '0;
         r_op    <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && bus.in_valid) begin
            r_pp  <= bus.pp_flat;
            r_op  <= bus.op;
            r_acc <= '0;
            r_row <= '0;
         end else if (r_state == ACC) begin
            r_acc <= r_acc + w_row_sum;
            r_row <= r_row + 2'd1;
         end
      end
   end
   // lanes share one adder; no carry may cross a lane boundary in SIMD modes
   for (genvar k = 0; k < NBLK; k++) begin : g_quad
      always_ff @(posedge clk)
         if (rst_n && r_state == ACC && r_op == MUL_OP_QUAD)
            assert ((PP_W+1)'(r_acc[k*PP_W +: PP_W]) + (PP_W+1)'(w_row_sum[k*PP_W +: PP_W]) < (PP_W+1)'(1 << PP_W));
   end
   for (genvar k = 0; k < 2; k++) begin : g_dual
      always_ff @(posedge clk)
         if (rst_n && r_state == ACC && r_op == MUL_OP_DUAL)
            assert ((2*PP_W+1)'(r_acc[k*2*PP_W +: 2*PP_W]) + (2*PP_W+1)'(w_row_sum[k*2*PP_W +: 2*PP_W]) < (2*PP_W+1)'(1 << (2*PP_W)));
   end
endmodule

// File: tb/tb_mantissa_pp_accumulator.sv
// tb_mantissa_pp_accumulator: directed table and corner sequences for mantissa_pp_accumulator
module tb_mantissa_pp_accumulator;
   import fmau_mul_pkg::*;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   always #5 clk = ~clk;
   mantissa_pp_accumulator_if bus ();
   mantissa_pp_accumulator dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   typedef struct {
      logic [1:0]   op;
      logic [223:0] pp;
      logic [55:0]  exp;
   } vec_t;
   vec_t vecs [10];
   function automatic logic [223:0] fill(input logic [13:0] d, input logic [13:0] o);
      logic [223:0] r;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            r[(4*i+j)*14 +: 14] = (i == j) ? d : o;
      return r;
   endfunction
   function automatic logic [223:0] one(input int i, input int j, input logic [13:0] v);
      logic [223:0] r;
      r = '0;
      r[(4*i+j)*14 +: 14] = v;
      return r;
   endfunction
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", nm, act, exp);
      end
   endtask
   // accept one set, scramble the inputs after the accept edge, wait for out_valid
   task automatic do_txn(input logic [1:0] op, input logic [223:0] pp, output logic [55:0] res,
                         output logic [1:0] ro, output int lat);
      @(negedge clk);
      chk("in_ready_before_accept", 64'(bus.in_ready), 64'd1);
      bus.op = op;
      bus.pp_flat = pp;
      bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.pp_flat = ~pp;
      bus.op = ~op;
      lat = 1;
      while (!bus.out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      res = bus.out;
      ro = bus.op_out;
   endtask
   logic [55:0] res, ref_out;
   logic [1:0]  ro;
   int          lat, n;
   initial begin
      vecs[0] = '{2'b00, fill(14'h3F01, 14'h3F01), 56'hFFFFFFE0000001};
      vecs[1] = '{2'b01, fill(14'h3F01, 14'h3F01), 56'hFFF8001FFF8001};
      vecs[2] = '{2'b10, fill(14'h3F01, 14'h3FFF), {4{14'h3F01}}};
      vecs[3] = '{2'b11, fill(14'h3F01, 14'h3F01), 56'hFFFFFFE0000001};
      vecs[4] = '{2'b00, one(3, 3, 14'h3FFF), 56'hFFFC0000000000};
      vecs[5] = '{2'b00, one(1, 2, 14'h1234), 56'h246800000};
      vecs[6] = '{2'b01, one(0, 2, 14'h3FFF), 56'h0};
      vecs[7] = '{2'b10, one(1, 1, 14'h1234), 56'h48D0000};
      vecs[8] = '{2'b01, one(2, 3, 14'h0ABC), 56'h55E000000000};
      vecs[9] = '{2'b10, one(0, 1, 14'h3FFF), 56'h0};
      bus.in_valid = 1'b0;
      bus.op = 2'b00;
      bus.pp_flat = '0;
      bus.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
      chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
      chk("reset_out", 64'(bus.out), 64'd0);
      chk("reset_op_out", 64'(bus.op_out), 64'd0);
      rst_n = 1'b1;
      for (int v = 0; v < 10; v++) begin
         do_txn(vecs[v].op, vecs[v].pp, res, ro, lat);
         chk($sformatf("vec%0d_latency", v), 64'(lat), 64'd5);
         chk($sformatf("vec%0d_out", v), 64'(res), 64'(vecs[v].exp));
         chk($sformatf("vec%0d_op_out", v), 64'(ro), 64'(vecs[v].op));
         @(negedge clk);
         chk($sformatf("vec%0d_idle_after", v), 64'({bus.in_ready, bus.out_valid}), 64'b10);
      end
      bus.out_ready = 1'b0;
      do_txn(2'b00, fill(14'h3F01, 14'h3F01), ref_out, ro, lat);
      chk("bp_latency", 64'(lat), 64'd5);
      chk("bp_out", 64'(ref_out), 64'hFFFFFFE0000001);
      bus.in_valid = 1'b1;
      bus.pp_flat = one(0, 0, 14'h0001);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk($sformatf("bp_hold%0d", c), 64'({bus.out_valid, bus.in_ready}), 64'b10);
         chk($sformatf("bp_out%0d", c), 64'(bus.out), 64'(ref_out));
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release", 64'({bus.in_ready, bus.out_valid}), 64'b10);
      @(negedge clk);
      bus.op = 2'b00;
      bus.pp_flat = fill(14'h3F01, 14'h3F01);
      bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_state", 64'({bus.out_valid, bus.in_ready}), 64'b01);
      chk("midrst_out", 64'(bus.out), 64'd0);
      rst_n = 1'b1;
      do_txn(2'b00, one(0, 0, 14'd5), res, ro, lat);
      chk("midrst_next_latency", 64'(lat), 64'd5);
      chk("midrst_next_out", 64'(res), 64'd5);
      @(negedge clk);
      bus.op = 2'b00;
      bus.pp_flat = fill(14'h3F01, 14'h3F01);
      bus.in_valid = 1'b1;
      @(posedge clk);
      n = 0;
      res = '0;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            bus.op = 2'b10;
            bus.pp_flat = fill(14'h3F01, 14'h3FFF);
         end
         if (bus.out_valid) res = bus.out;
      end while (!bus.in_ready && n < 20);
      chk("b2b_gap", 64'(n), 64'd6);
      chk("b2b_first_out", 64'(res), 64'hFFFFFFE0000001);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("b2b_second_latency", 64'(lat), 64'd5);
      chk("b2b_second_out", 64'(bus.out), 64'({4{14'h3F01}}));
      chk("b2b_second_op_out", 64'(bus.op_out), 64'd2);
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mantissa_pp_accumulator.md
Name: mantissa_pp_accumulator

Overview:
- Downstream stage of the 28x28 mantissa multiplier in the posit FMAU.
- Consumes the 16 raw 14-bit partial products produced by the 4x4 array of unsigned 7x7 multipliers, together with the SIMD mode `op`.
- Sums them iteratively, one partial-product row per cycle, into a 56-bit mantissa product.
- Uses a valid/ready handshake on both sides so the downstream normaliser/adder can apply backpressure.

Parameters:
- PP_W, 14, width of one partial product (2 x 7-bit block width).
- NBLK, 4, number of 7-bit blocks per operand; the partial-product array is NBLK x NBLK.
- OUT_W, NBLK*PP_W (56), product width; derived, not to be overridden.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  partial-product set is valid.
- in_ready  out  1  block can accept a set.
- op  in  2  mode: 00 one 28x28; 01 two 14x14; 10 four 7x7; 11 reserved, treated as 00.
- pp_flat  in  NBLK*NBLK*PP_W (224)  pp[i][j] at bits [(4*i+j)*14 +: 14]; i indexes A blocks, j indexes B blocks.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts product.
- out  out  OUT_W (56)  product / packed lane products.
- op_out  out  2  op captured with this product.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, row counter=0, accumulator=0, captured pp/op cleared.
  - Outputs: in_ready=1, out_valid=0, out=0, op_out=0.
  - Reset mid-operation discards the operation in progress; no output is produced for it.
- States: IDLE, ACC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture pp_flat and op, clear accumulator, row=0, go to ACC.
- ACC:
  - in_ready=0.
  - Each cycle add the masked terms of row r: acc += sum over j of (keep(r,j) ? pp[r][j] : 0) << (7*(r+j)).
  - r counts 0..3; after r=3 go to DONE.
- DONE:
  - out_valid=1, out=acc, op_out=captured op.
  - Hold all three stable until out_ready=1.
  - On out_valid&out_ready go to IDLE.
- Timing and throughput:
  - Latency: accept edge at cycle T -> out_valid=1 in cycle T+5 (4 accumulate cycles plus the transition into DONE).
  - Throughput: one product per 6 cycles with out_ready held high.
  - No input is accepted while in ACC or DONE.
- Mask keep(i,j):
  - op=00/11: all terms kept.
  - op=01: kept iff i[1]==j[1] (same 14-bit half).
  - op=10: kept iff i==j.
- Placement is identical in all modes: every kept term sits at offset 7*(i+j).
  - op=01: low 14x14 product lands in out[27:0], high product in out[55:28].
  - op=10: lane k (0..3) occupies out[14k+13:14k].
  - Lane sums never exceed their field, so no carry crosses a lane boundary; no explicit lane isolation is required, but assertions check it.
- Arithmetic:
  - Unsigned throughout; the accumulator is exactly OUT_W bits.
  - The full 28x28 maximum ((2^28-1)^2) fits in OUT_W, so no overflow is possible.
- Boundary conditions:
  - in_valid asserted during ACC/DONE: ignored; the upstream holds it.
  - out_ready asserted before DONE: no effect.
  - pp_flat changing after the accept edge: no effect, because inputs are captured at accept.

Decomposition:
- Shared package (fmau_mul_pkg):
  - Constants PP_W, NBLK, OUT_W.
  - op encodings MUL_OP_FULL=2'b00, MUL_OP_DUAL=2'b01, MUL_OP_QUAD=2'b10.
  - State enum {IDLE, ACC, DONE}.
- Sub-module pp_row_shifter (combinational): takes row index, captured row, and op; returns the masked, shifted row sum (OUT_W bits).
- The FSM and accumulator stay in the top module.

Test Plan:
- Full mode: op=00, every pp=0x3F01 (127*127) -> out=0xFFFFFFE0000001, op_out=00, out_valid exactly 5 cycles after the accept edge.
- Dual mode: op=01, every pp=0x3F01 -> out[27:0]=0xFFF8001 and out[55:28]=0xFFF8001 (16383^2); off-diagonal half terms must be excluded.
- Quad mode: op=10, pp[k][k]=0x3F01, all off-diagonal pp=0x3FFF -> each 14-bit lane=0x3F01.
- Backpressure: out_ready held 0 for 10 cycles in DONE -> out/out_valid stable, in_ready=0 throughout; on out_ready=1, IDLE and in_ready=1 the next cycle.
- Reset mid-operation: rst_n=0 during ACC row 2 -> next cycle out_valid=0, in_ready=1, out=0; the following op=00 with pp[0][0]=5 and all others 0 yields out=5.
- Back-to-back: in_valid held with two sets while out_ready=1 -> second accepted exactly 6 cycles after the first; both results correct.
